aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
Sequential round-key scheduler for the AES-128 core. On a start pulse it runs one key-expansion step per clock (RotWord/SubWord/Rcon plus the XOR chain), storing the cipher key and all 10 round keys in an internal table. After expansion it serves round keys to the cipher datapath by index through a registered request/response port. This replaces free-running combinational round tracking with an explicit round counter and FSM.

Parameters:
ROUNDS, 10, number of expansion rounds; table depth is ROUNDS+1.
KEY_W, 128, key and round-key width in bits.

Ports:
iClk  in  1  clock; all state updates on the rising edge.
iRsn  in  1  asynchronous active-low reset.
iKeyStart  in  1  single-cycle start pulse; honoured only in IDLE or READY.
iAesKey  in  128  cipher key; sampled at the edge where iKeyStart is accepted.
oBusy  out  1  high while state is EXPAND.
oKeyDone  out  1  one-cycle pulse when the table becomes complete.
oKeyVld  out  1  level signal; the table holds a complete, consistent schedule.
iRkReq  in  1  round-key read request.
iRkIdx  in  4  requested round index, 0..10.
oRkVld  out  1  read response valid, exactly 1 cycle after iRkReq.
oRkData  out  128  round key for the requested index; 0 on error.
oRkErr  out  1  qualifies oRkVld; high for an illegal or premature read.

Behaviour:
- Reset (iRsn=0, asynchronous):
  - state=IDLE, round counter=0, all table entries=0.
  - oBusy, oKeyDone, oKeyVld, oRkVld, oRkErr = 0; oRkData = 0.
  - Reset asserted mid-expansion aborts it; no partial keys survive.
- FSM states: IDLE, EXPAND, DONE, READY.
- IDLE or READY with iKeyStart=1:
  - rk[0]<=iAesKey, round<=1, oKeyVld<=0, next state EXPAND.
- EXPAND, round r (1..10):
  - rk[r]<=step(rk[r-1], r); round<=r+1.
  - At r=10, next state is DONE.
  - iKeyStart during EXPAND is ignored (not queued).
- DONE:
  - oKeyDone=1 for exactly this cycle and oKeyVld<=1; next state READY.
- READY: holds the table until the next accepted start.
- Latency: start accepted at edge E0; rk[r] is written at edge Er; oKeyDone is high in the cycle after E10. That is 11 cycles from start to done.
- Step function (per round):
  - t = SubWord(RotWord(w3)) ^ Rcon(r), where w3 = prev[31:0].
  - Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36 placed in byte [31:24].
  - new[127:96] = prev[127:96] ^ t.
  - Each following 32-bit word = the previous key's word ^ the new word above it.
- Reads (one response per request, no backpressure):
  - iRkReq at edge E gives oRkVld=1 in the next cycle.
  - oRkErr=1 and data 0 if iRkIdx>10, or if oKeyVld=0 at E.
  - Otherwise oRkErr=0 and oRkData = rk[iRkIdx] as sampled at E.
- Read and start at the same edge in READY: the read returns the pre-start entry with err=0; the table is then rebuilt.
- oRkVld/oRkErr deassert the cycle after a cycle with no request.
- oKeyDone and oKeyVld rise in the same cycle.

Optional Feature:
AES_KEY_ZEROIZE_EN
- Defined:
  - Adds input iZeroize (1 bit).
  - When high at an edge, from any state: all table entries<=0, round<=0, state<=IDLE, oKeyVld<=0, oKeyDone<=0.
  - A concurrent read returns err=1.
  - Zeroize has priority over iKeyStart.
- Undefined: the port is absent; table contents persist until reset or the next start.

Decomposition:
- Shared package aes_pkg holds:
  - KEY_W and ROUNDS constants.
  - The FSM state typedef (IDLE/EXPAND/DONE/READY).
  - The Rcon constant table.
  - The S-box function, shared with the SubBytes logic.
- One sub-module, aes_key_step:
  - Combinational; inputs prev key and 4-bit round; output next key.
  - Instantiated once; the controller feeds it rk[round-1] through a mux.

Test Plan:
- Reset then read idx 0 → oRkVld=1, oRkErr=1, oRkData=0; oKeyVld=0.
- Start with key 2b7e151628aed2a6abf7158809cf4f3c → oKeyDone 11 cycles later; read idx1 = a0fafe1788542cb123a339392a6c7605; read idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Read idx 11 and idx 15 in READY → oRkErr=1, data 0. Read idx 5 during EXPAND → oRkErr=1.
- Second iKeyStart at cycle 4 of EXPAND → ignored; oKeyDone still at cycle 11 with the original key's schedule.
- iRsn pulsed low at round 6 → all outputs 0 immediately. A restart completes a correct schedule; back-to-back start in READY concurrent with a read returns the old entry.
- With AES_KEY_ZEROIZE_EN: iZeroize in READY → oKeyVld=0 next cycle; read idx0 gives err=1; a new start rebuilds correctly.

Source files
------------

// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared AES-128 definitions: widths, scheduler FSM states, Rcon table and S-box lookup.
// Latency: none, constants and pure combinational functions only.
// Backpressure: not applicable.
package aes_pkg;

  localparam int KEY_W = 128;
  localparam int ROUNDS = 10;
  localparam logic [3:0] ROUND_LAST = 4'(ROUNDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2,
    READY  = 2'd3
  } keyStateT;

  // Indexed directly by the 4-bit round number; entry 0 and 11..15 are never used.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Start/status and round-key read bundle between the cipher datapath and the key scheduler.
// Latency: wires only; the read response arrives one cycle after the request.
// Backpressure: none, every request gets exactly one response. Optional AES_KEY_ZEROIZE_EN adds iZeroize.
interface aes_key_sched_ctrl_if;
  import aes_pkg::*;

  logic             iKeyStart;
  logic [KEY_W-1:0] iAesKey;
  logic             oBusy;
  logic             oKeyDone;
  logic             oKeyVld;
  logic             iRkReq;
  logic [3:0]       iRkIdx;
  logic             oRkVld;
  logic [KEY_W-1:0] oRkData;
  logic             oRkErr;
`ifdef AES_KEY_ZEROIZE_EN
  logic             iZeroize;
`endif

  modport master (
    output iKeyStart, iAesKey, iRkReq, iRkIdx,
`ifdef AES_KEY_ZEROIZE_EN
    output iZeroize,
`endif
    input  oBusy, oKeyDone, oKeyVld, oRkVld, oRkData, oRkErr
  );

  modport slave (
    input  iKeyStart, iAesKey, iRkReq, iRkIdx,
`ifdef AES_KEY_ZEROIZE_EN
    input  iZeroize,
`endif
    output oBusy, oKeyDone, oKeyVld, oRkVld, oRkData, oRkErr
  );

endinterface

// File: rtl/aes_key_sched_ctrl_step.sv
// One AES-128 key-expansion step: RotWord/SubWord/Rcon on the last word, then the XOR chain.
// Latency: purely combinational.
// Backpressure: none.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] prevKey,
  input  logic [3:0]       round,
  output logic [KEY_W-1:0] nextKey
);

  logic [31:0] rotW;
  logic [31:0] tW;
  logic [31:0] w0, w1, w2, w3;

  // Each new word folds in the new word above it, so the four XORs form a chain.
  always_comb begin
    rotW = {prevKey[23:0], prevKey[31:24]};
    tW   = subWord(rotW) ^ {RCON[round], 24'h000000};
    w0   = prevKey[127:96] ^ tW;
    w1   = prevKey[95:64]  ^ w0;
    w2   = prevKey[63:32]  ^ w1;
    w3   = prevKey[31:0]   ^ w2;
    nextKey = {w0, w1, w2, w3};
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 round-key scheduler: expands one round per clock into an 11-entry table, then serves reads by index.
// Latency: 11 cycles from accepted start to oKeyDone; read response 1 cycle after iRkReq.
// Backpressure: none; starts outside IDLE/READY are dropped. Optional AES_KEY_ZEROIZE_EN adds iZeroize.
module aes_key_sched_ctrl
  import aes_pkg::*;
(
  input logic                iClk,
  input logic                iRsn,
  aes_key_sched_ctrl_if.slave keyIf
);

  keyStateT         state, stateNxt;
  logic [3:0]       round;
  logic [KEY_W-1:0] rk [ROUNDS+1];
  logic [KEY_W-1:0] stepIn, stepOut;
  logic             zeroize;
  logic             startAcc;
  logic             keyVld;
  logic             rkVld, rkErr;
  logic [KEY_W-1:0] rkData;

`ifdef AES_KEY_ZEROIZE_EN
  assign zeroize = keyIf.iZeroize;
`else
  assign zeroize = 1'b0;
`endif

  // The table is only trustworthy once the last round has landed and until a rebuild starts.
  assign keyVld   = (state == DONE) || (state == READY);
  assign startAcc = keyIf.iKeyStart && !zeroize && ((state == IDLE) || (state == READY));
  assign stepIn   = rk[(round == 4'd0) ? 4'd0 : (round - 4'd1)];

  aes_key_step uStep (
    .prevKey (stepIn),
    .round   (round),
    .nextKey (stepOut)
  );

  // FSM state register.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) state <= IDLE;
    else       state <= stateNxt;
  end

  // Next-state decode; zeroize overrides everything, including a concurrent start.
  always_comb begin
    stateNxt = state;
    if (zeroize) begin
      stateNxt = IDLE;
    end else begin
      case (state)
        IDLE, READY: if (startAcc) stateNxt = EXPAND;
        EXPAND:      if (round == ROUND_LAST) stateNxt = DONE;
        DONE:        stateNxt = READY;
        default:     stateNxt = IDLE;
      endcase
    end
  end

  // Key table and round counter: load the cipher key on start, then one round key per cycle.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      round <= 4'd0;
      for (int i = 0; i <= ROUNDS; i++) rk[i] <= '0;
    end else if (zeroize) begin
      round <= 4'd0;
      for (int i = 0; i <= ROUNDS; i++) rk[i] <= '0;
    end else if (startAcc) begin
      rk[0] <= keyIf.iAesKey;
      round <= 4'd1;
    end else if (state == EXPAND) begin
      rk[round] <= stepOut;
      round     <= (round == ROUND_LAST) ? 4'd0 : (round + 4'd1);
    end
  end

  // Read port: samples the table before any same-edge rebuild, so a read racing a start sees the old key.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      rkVld  <= 1'b0;
      rkErr  <= 1'b0;
      rkData <= '0;
    end else begin
      rkVld <= keyIf.iRkReq;
      if (keyIf.iRkReq && keyVld && !zeroize && (keyIf.iRkIdx <= ROUND_LAST)) begin
        rkErr  <= 1'b0;
        rkData <= rk[keyIf.iRkIdx];
      end else begin
        rkErr  <= keyIf.iRkReq;
        rkData <= '0;
      end
    end
  end

  assign keyIf.oBusy    = (state == EXPAND);
  assign keyIf.oKeyDone = (state == DONE);
  assign keyIf.oKeyVld  = keyVld;
  assign keyIf.oRkVld   = rkVld;
  assign keyIf.oRkErr   = rkErr;
  assign keyIf.oRkData  = rkData;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for the AES-128 key scheduler: random keys checked against a FIPS-197 style word-recurrence model.
// The model derives its S-box from GF(2^8) inversion plus the affine map, independent of the RTL table.
// Define AES_KEY_ZEROIZE_EN to also exercise the zeroize path.
module tb_aes_key_sched_ctrl;

  typedef logic [127:0] tabT [11];

  logic iClk;
  logic iRsn;
  int   vecs;
  int   errs;
  logic [7:0] sboxTab [256];
  tabT  expTab;

  aes_key_sched_ctrl_if keyIf ();

  aes_key_sched_ctrl dut (
    .iClk  (iClk),
    .iRsn  (iRsn),
    .keyIf (keyIf)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(b));
      sboxTab[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic tabT expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    tabT tab;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) tab[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return tab;
  endfunction

  function automatic logic [127:0] randKey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic readIdx(input logic [3:0] idx, output logic v, output logic e, output logic [127:0] d);
    keyIf.iRkReq = 1'b1;
    keyIf.iRkIdx = idx;
    tick();
    keyIf.iRkReq = 1'b0;
    v = keyIf.oRkVld;
    e = keyIf.oRkErr;
    d = keyIf.oRkData;
  endtask

  // Issues a start and waits (bounded) for oKeyDone; cyc counts edges from the accepting edge.
  task automatic runStart(input logic [127:0] key, output int cyc);
    keyIf.iKeyStart = 1'b1;
    keyIf.iAesKey   = key;
    tick();
    keyIf.iKeyStart = 1'b0;
    cyc = 1;
    while (keyIf.oKeyDone !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic v, e;
    logic [127:0] d;
    iRsn = 1'b0;
    #12;
    vecs++;
    if ({keyIf.oBusy, keyIf.oKeyDone, keyIf.oKeyVld, keyIf.oRkVld, keyIf.oRkErr} !== 5'b0) begin
      errs++;
      $display("FAIL reset_flags: got %b want 00000",
               {keyIf.oBusy, keyIf.oKeyDone, keyIf.oKeyVld, keyIf.oRkVld, keyIf.oRkErr});
    end
    vecs++;
    if (keyIf.oRkData !== 128'h0) begin
      errs++;
      $display("FAIL reset_data: got %h want 0", keyIf.oRkData);
    end
    @(negedge iClk);
    iRsn = 1'b1;
    tick();
    readIdx(4'd0, v, e, d);
    vecs++;
    if ({v, e, keyIf.oKeyVld} !== 3'b110 || d !== 128'h0) begin
      errs++;
      $display("FAIL reset_read0: got vld=%b err=%b keyVld=%b data=%h want 1 1 0 0", v, e, keyIf.oKeyVld, d);
    end
    tick();
    vecs++;
    if ({keyIf.oRkVld, keyIf.oRkErr} !== 2'b00) begin
      errs++;
      $display("FAIL idle_rsp: got vld=%b err=%b want 0 0", keyIf.oRkVld, keyIf.oRkErr);
    end
  endtask

  task automatic test_kat();
    int cyc;
    logic v, e;
    logic [127:0] d, key;
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    runStart(key, cyc);
    expTab = expand(key);
    vecs++;
    if (cyc != 11) begin
      errs++;
      $display("FAIL kat_latency: got %0d cycles want 11", cyc);
    end
    vecs++;
    if (keyIf.oKeyVld !== 1'b1) begin
      errs++;
      $display("FAIL kat_keyvld_with_done: got %b want 1", keyIf.oKeyVld);
    end
    readIdx(4'd1, v, e, d);
    vecs++;
    if (keyIf.oKeyDone !== 1'b0) begin
      errs++;
      $display("FAIL kat_done_pulse: got %b want 0", keyIf.oKeyDone);
    end
    vecs++;
    if ({v, e} !== 2'b10 || d !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      errs++;
      $display("FAIL kat_idx1: got vld=%b err=%b data=%h want 1 0 a0fafe1788542cb123a339392a6c7605", v, e, d);
    end
    readIdx(4'd10, v, e, d);
    vecs++;
    if ({v, e} !== 2'b10 || d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errs++;
      $display("FAIL kat_idx10: got vld=%b err=%b data=%h want 1 0 d014f9a8c9ee2589e13f0cc8b6630ca6", v, e, d);
    end
    readIdx(4'd0, v, e, d);
    vecs++;
    if ({v, e} !== 2'b10 || d !== key) begin
      errs++;
      $display("FAIL kat_idx0: got vld=%b err=%b data=%h want 1 0 %h", v, e, d, key);
    end
  endtask

  // Requests held every cycle with random indices, including the illegal 11..15 range.
  task automatic test_read_stream();
    logic [3:0] idx;
    logic [127:0] want;
    keyIf.iRkReq = 1'b1;
    for (int n = 0; n < 26; n++) begin
      if (n == 0)      idx = 4'd11;
      else if (n == 1) idx = 4'd15;
      else             idx = 4'($urandom_range(0, 15));
      keyIf.iRkIdx = idx;
      tick();
      want = (idx > 4'd10) ? 128'h0 : expTab[idx];
      vecs++;
      if (keyIf.oRkVld !== 1'b1 || keyIf.oRkErr !== (idx > 4'd10) || keyIf.oRkData !== want) begin
        errs++;
        $display("FAIL read_stream idx=%0d: got vld=%b err=%b data=%h want 1 %b %h",
                 idx, keyIf.oRkVld, keyIf.oRkErr, keyIf.oRkData, idx > 4'd10, want);
      end
    end
    keyIf.iRkReq = 1'b0;
    tick();
  endtask

  task automatic test_expand_ignore();
    int cyc;
    logic [127:0] keyA, keyB;
    logic v, e;
    logic [127:0] d;
    keyA = randKey();
    keyB = randKey();
    keyIf.iKeyStart = 1'b1;
    keyIf.iAesKey   = keyA;
    tick();
    keyIf.iKeyStart = 1'b0;
    keyIf.iAesKey   = randKey();
    cyc = 1;
    repeat (3) begin tick(); cyc++; end
    keyIf.iKeyStart = 1'b1;
    keyIf.iAesKey   = keyB;
    keyIf.iRkReq    = 1'b1;
    keyIf.iRkIdx    = 4'd5;
    tick();
    cyc++;
    keyIf.iKeyStart = 1'b0;
    keyIf.iRkReq    = 1'b0;
    vecs++;
    if ({keyIf.oRkVld, keyIf.oRkErr, keyIf.oBusy} !== 3'b111 || keyIf.oRkData !== 128'h0) begin
      errs++;
      $display("FAIL expand_read: got vld=%b err=%b busy=%b data=%h want 1 1 1 0",
               keyIf.oRkVld, keyIf.oRkErr, keyIf.oBusy, keyIf.oRkData);
    end
    while (keyIf.oKeyDone !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    vecs++;
    if (cyc != 11) begin
      errs++;
      $display("FAIL ignore_latency: got %0d cycles want 11", cyc);
    end
    expTab = expand(keyA);
    for (int i = 0; i <= 10; i++) begin
      readIdx(4'(i), v, e, d);
      vecs++;
      if ({v, e} !== 2'b10 || d !== expTab[i]) begin
        errs++;
        $display("FAIL ignore_table idx=%0d: got vld=%b err=%b data=%h want 1 0 %h", i, v, e, d, expTab[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic v, e;
    logic [127:0] d, key;
    keyIf.iKeyStart = 1'b1;
    keyIf.iAesKey   = randKey();
    tick();
    keyIf.iKeyStart = 1'b0;
    repeat (4) tick();
    keyIf.iRkReq = 1'b1;
    keyIf.iRkIdx = 4'd3;
    tick();
    keyIf.iRkReq = 1'b0;
    vecs++;
    if ({keyIf.oBusy, keyIf.oRkVld, keyIf.oRkErr} !== 3'b111) begin
      errs++;
      $display("FAIL premid_state: got busy=%b vld=%b err=%b want 1 1 1", keyIf.oBusy, keyIf.oRkVld, keyIf.oRkErr);
    end
    #2 iRsn = 1'b0;
    #1;
    vecs++;
    if ({keyIf.oBusy, keyIf.oKeyDone, keyIf.oKeyVld, keyIf.oRkVld, keyIf.oRkErr} !== 5'b0 ||
        keyIf.oRkData !== 128'h0) begin
      errs++;
      $display("FAIL midreset_outputs: got flags=%b data=%h want 00000 0",
               {keyIf.oBusy, keyIf.oKeyDone, keyIf.oKeyVld, keyIf.oRkVld, keyIf.oRkErr}, keyIf.oRkData);
    end
    tick();
    iRsn = 1'b1;
    tick();
    readIdx(4'd0, v, e, d);
    vecs++;
    if ({v, e, keyIf.oBusy} !== 3'b110 || d !== 128'h0) begin
      errs++;
      $display("FAIL midreset_read: got vld=%b err=%b busy=%b data=%h want 1 1 0 0", v, e, keyIf.oBusy, d);
    end
    key = randKey();
    runStart(key, cyc);
    vecs++;
    if (cyc != 11) begin
      errs++;
      $display("FAIL restart_latency: got %0d cycles want 11", cyc);
    end
    expTab = expand(key);
    for (int i = 0; i <= 10; i++) begin
      readIdx(4'(i), v, e, d);
      vecs++;
      if ({v, e} !== 2'b10 || d !== expTab[i]) begin
        errs++;
        $display("FAIL restart_table idx=%0d: got vld=%b err=%b data=%h want 1 0 %h", i, v, e, d, expTab[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [3:0] r;
    logic v, e;
    logic [127:0] d, key;
    key = randKey();
    r = 4'($urandom_range(0, 10));
    keyIf.iKeyStart = 1'b1;
    keyIf.iAesKey   = key;
    keyIf.iRkReq    = 1'b1;
    keyIf.iRkIdx    = r;
    tick();
    keyIf.iKeyStart = 1'b0;
    keyIf.iRkReq    = 1'b0;
    vecs++;
    if ({keyIf.oRkVld, keyIf.oRkErr} !== 2'b10 || keyIf.oRkData !== expTab[r]) begin
      errs++;
      $display("FAIL b2b_old_entry idx=%0d: got vld=%b err=%b data=%h want 1 0 %h",
               r, keyIf.oRkVld, keyIf.oRkErr, keyIf.oRkData, expTab[r]);
    end
    vecs++;
    if ({keyIf.oBusy, keyIf.oKeyVld} !== 2'b10) begin
      errs++;
      $display("FAIL b2b_state: got busy=%b keyVld=%b want 1 0", keyIf.oBusy, keyIf.oKeyVld);
    end
    cyc = 1;
    while (keyIf.oKeyDone !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    vecs++;
    if (cyc != 11) begin
      errs++;
      $display("FAIL b2b_latency: got %0d cycles want 11", cyc);
    end
    expTab = expand(key);
    for (int i = 0; i <= 10; i++) begin
      readIdx(4'(i), v, e, d);
      vecs++;
      if ({v, e} !== 2'b10 || d !== expTab[i]) begin
        errs++;
        $display("FAIL b2b_table idx=%0d: got vld=%b err=%b data=%h want 1 0 %h", i, v, e, d, expTab[i]);
      end
    end
  endtask

  task automatic test_random_keys();
    int cyc;
    logic [3:0] r;
    logic v, e;
    logic [127:0] d, key;
    for (int n = 0; n < 20; n++) begin
      key = randKey();
      runStart(key, cyc);
      vecs++;
      if (cyc != 11) begin
        errs++;
        $display("FAIL rand_latency key=%h: got %0d cycles want 11", key, cyc);
      end
      expTab = expand(key);
      readIdx(4'd10, v, e, d);
      vecs++;
      if ({v, e} !== 2'b10 || d !== expTab[10]) begin
        errs++;
        $display("FAIL rand_idx10 key=%h: got vld=%b err=%b data=%h want 1 0 %h", key, v, e, d, expTab[10]);
      end
      r = 4'($urandom_range(0, 10));
      readIdx(r, v, e, d);
      vecs++;
      if ({v, e} !== 2'b10 || d !== expTab[r]) begin
        errs++;
        $display("FAIL rand_idx%0d key=%h: got vld=%b err=%b data=%h want 1 0 %h", r, key, v, e, d, expTab[r]);
      end
    end
  endtask

`ifdef AES_KEY_ZEROIZE_EN
  task automatic test_zeroize();
    int cyc;
    logic v, e;
    logic [127:0] d, key;
    key = randKey();
    keyIf.iZeroize  = 1'b1;
    keyIf.iKeyStart = 1'b1;
    keyIf.iAesKey   = randKey();
    keyIf.iRkReq    = 1'b1;
    keyIf.iRkIdx    = 4'd0;
    tick();
    keyIf.iZeroize  = 1'b0;
    keyIf.iKeyStart = 1'b0;
    keyIf.iRkReq    = 1'b0;
    vecs++;
    if ({keyIf.oKeyVld, keyIf.oBusy, keyIf.oKeyDone} !== 3'b000) begin
      errs++;
      $display("FAIL zeroize_state: got keyVld=%b busy=%b done=%b want 0 0 0",
               keyIf.oKeyVld, keyIf.oBusy, keyIf.oKeyDone);
    end
    vecs++;
    if ({keyIf.oRkVld, keyIf.oRkErr} !== 2'b11 || keyIf.oRkData !== 128'h0) begin
      errs++;
      $display("FAIL zeroize_read: got vld=%b err=%b data=%h want 1 1 0",
               keyIf.oRkVld, keyIf.oRkErr, keyIf.oRkData);
    end
    readIdx(4'd0, v, e, d);
    vecs++;
    if ({v, e} !== 2'b11 || d !== 128'h0) begin
      errs++;
      $display("FAIL zeroize_after_read: got vld=%b err=%b data=%h want 1 1 0", v, e, d);
    end
    runStart(key, cyc);
    vecs++;
    if (cyc != 11) begin
      errs++;
      $display("FAIL zeroize_rebuild_latency: got %0d cycles want 11", cyc);
    end
    expTab = expand(key);
    for (int i = 0; i <= 10; i++) begin
      readIdx(4'(i), v, e, d);
      vecs++;
      if ({v, e} !== 2'b10 || d !== expTab[i]) begin
        errs++;
        $display("FAIL zeroize_rebuild idx=%0d: got vld=%b err=%b data=%h want 1 0 %h", i, v, e, d, expTab[i]);
      end
    end
  endtask
`endif

  initial begin
    vecs = 0;
    errs = 0;
    iRsn = 1'b0;
    keyIf.iKeyStart = 1'b0;
    keyIf.iAesKey   = 128'h0;
    keyIf.iRkReq    = 1'b0;
    keyIf.iRkIdx    = 4'd0;
`ifdef AES_KEY_ZEROIZE_EN
    keyIf.iZeroize  = 1'b0;
`endif
    buildSbox();
    test_reset();
    test_kat();
    test_read_stream();
    test_expand_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random_keys();
`ifdef AES_KEY_ZEROIZE_EN
    test_zeroize();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
